// File: rtl/rr_mux_stage.sv
// N-channel registered multiplexer with valid/ready on every port.
// Fixed-select or round-robin arbitration feeding a single output register.
module rr_mux_stage #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    localparam int SEL_W   = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          s,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          out_ch
);

    localparam int unsigned NCH = CHANNELS;

    logic [WIDTH-1:0]    r_out_data;
    logic                r_out_valid;
    logic [SEL_W-1:0]    r_out_ch;
    logic [SEL_W-1:0]    r_ptr;

    logic                w_free;
    logic                w_any;
    logic [SEL_W-1:0]    w_gidx;
    logic [CHANNELS-1:0] w_grant;
    logic [WIDTH-1:0]    w_gdata;

    // Free depends only on registered state and out_ready, so in_ready has no loop.
    assign w_free = !r_out_valid || out_ready;

    always_comb begin
        int unsigned idx;
        int unsigned sidx;
        idx    = 0;
        sidx   = 32'(s);
        w_any  = 1'b0;
        w_gidx = '0;
        if (mode) begin
            // First requester at or above ptr, wrapping to channel 0.
            for (int unsigned k = 0; k < NCH; k++) begin
                idx = (32'(r_ptr) + k) % NCH;
                if (!w_any && in_valid[idx]) begin
                    w_any  = 1'b1;
                    w_gidx = SEL_W'(idx);
                end
            end
        end else if (sidx < NCH) begin
            if (in_valid[sidx]) begin
                w_any  = 1'b1;
                w_gidx = SEL_W'(sidx);
            end
        end
    end

    assign w_grant  = w_any ? (CHANNELS'(1) << w_gidx) : '0;
    assign w_gdata  = in_data[32'(w_gidx)*WIDTH +: WIDTH];
    assign in_ready = rst ? '0 : (w_grant & {CHANNELS{w_free}});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_ptr       <= '0;
        end else if (w_free) begin
            if (w_any) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_gdata;
                r_out_ch    <= w_gidx;
                if (mode) begin
                    r_ptr <= (32'(w_gidx) == NCH - 1) ? '0 : w_gidx + SEL_W'(1);
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_rr_mux_stage.sv
// Directed-vector bench for rr_mux_stage (WIDTH=4, CHANNELS=4).
module tb_rr_mux_stage;

    logic        clk;
    logic        rst;
    logic [15:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  s;
    logic [3:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_ch;

    int n_pass;
    int n_total;

    rr_mux_stage #(.WIDTH(4), .CHANNELS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .s         (s),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       mode;
        logic [1:0] s;
        logic [3:0] vld;
        logic       ordy;
        logic [3:0] e_rdy;
        logic       e_ov;
        logic [3:0] e_od;
        logic [1:0] e_ch;
        logic [1:0] e_ptr;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic r, logic m, logic [1:0] sel, logic [3:0] v, logic o,
                                logic [3:0] er, logic eov, logic [3:0] eod,
                                logic [1:0] ech, logic [1:0] ep);
        vec_t x;
        x.rst = r; x.mode = m; x.s = sel; x.vld = v; x.ordy = o;
        x.e_rdy = er; x.e_ov = eov; x.e_od = eod; x.e_ch = ech; x.e_ptr = ep;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst = 1'b1; mode = 1'b0; s = '0; in_valid = '0; out_ready = 1'b1;
        in_data = 16'hC53A;   // ch0=A ch1=3 ch2=5 ch3=C

        //               rst mode s   vld    ordy  e_rdy   ov  od    ch  ptr
        vt.push_back(mk(1, 0, 0, 4'hF, 1, 4'b0000, 0, 4'h0, 0, 0)); // reset
        vt.push_back(mk(0, 0, 0, 4'hF, 1, 4'b0001, 1, 4'hA, 0, 0)); // fixed s=0..3
        vt.push_back(mk(0, 0, 1, 4'hF, 1, 4'b0010, 1, 4'h3, 1, 0));
        vt.push_back(mk(0, 0, 2, 4'hF, 1, 4'b0100, 1, 4'h5, 2, 0));
        vt.push_back(mk(0, 0, 3, 4'hF, 1, 4'b1000, 1, 4'hC, 3, 0));
        vt.push_back(mk(0, 1, 0, 4'hF, 1, 4'b0001, 1, 4'hA, 0, 1)); // rr fairness x8
        vt.push_back(mk(0, 1, 0, 4'hF, 1, 4'b0010, 1, 4'h3, 1, 2));
        vt.push_back(mk(0, 1, 0, 4'hF, 1, 4'b0100, 1, 4'h5, 2, 3));
        vt.push_back(mk(0, 1, 0, 4'hF, 1, 4'b1000, 1, 4'hC, 3, 0));
        vt.push_back(mk(0, 1, 0, 4'hF, 1, 4'b0001, 1, 4'hA, 0, 1));
        vt.push_back(mk(0, 1, 0, 4'hF, 1, 4'b0010, 1, 4'h3, 1, 2));
        vt.push_back(mk(0, 1, 0, 4'hF, 1, 4'b0100, 1, 4'h5, 2, 3));
        vt.push_back(mk(0, 1, 0, 4'hF, 1, 4'b1000, 1, 4'hC, 3, 0));
        vt.push_back(mk(0, 1, 0, 4'hA, 1, 4'b0010, 1, 4'h3, 1, 2)); // sparse 1,3
        vt.push_back(mk(0, 1, 0, 4'hA, 1, 4'b1000, 1, 4'hC, 3, 0));
        vt.push_back(mk(0, 1, 0, 4'hA, 1, 4'b0010, 1, 4'h3, 1, 2));
        vt.push_back(mk(0, 1, 0, 4'h8, 1, 4'b1000, 1, 4'hC, 3, 0)); // drop ch1 at ptr=2, wrap
        vt.push_back(mk(0, 1, 0, 4'h8, 1, 4'b1000, 1, 4'hC, 3, 0));
        vt.push_back(mk(0, 1, 0, 4'hF, 0, 4'b0000, 1, 4'hC, 3, 0)); // back-pressure x3
        vt.push_back(mk(0, 1, 0, 4'hF, 0, 4'b0000, 1, 4'hC, 3, 0));
        vt.push_back(mk(0, 1, 0, 4'hF, 0, 4'b0000, 1, 4'hC, 3, 0));
        vt.push_back(mk(0, 1, 0, 4'hF, 1, 4'b0001, 1, 4'hA, 0, 1)); // drain + load
        vt.push_back(mk(0, 1, 0, 4'h0, 1, 4'b0000, 0, 4'hA, 0, 1)); // free, no grant
        vt.push_back(mk(0, 1, 0, 4'h4, 0, 4'b0100, 1, 4'h5, 2, 3)); // empty reg is free
        vt.push_back(mk(0, 1, 0, 4'h2, 1, 4'b0010, 1, 4'h3, 1, 2)); // ptr=2, word held
        vt.push_back(mk(1, 1, 0, 4'hF, 1, 4'b0000, 0, 4'h0, 0, 0)); // reset mid-stream
        vt.push_back(mk(0, 1, 0, 4'hF, 1, 4'b0001, 1, 4'hA, 0, 1)); // first grant ch0
        vt.push_back(mk(0, 1, 0, 4'hF, 1, 4'b0010, 1, 4'h3, 1, 2)); // ch1 word
        vt.push_back(mk(0, 0, 2, 4'hF, 0, 4'b0000, 1, 4'h3, 1, 2)); // switch to s=2, held
        vt.push_back(mk(0, 0, 2, 4'hF, 1, 4'b0100, 1, 4'h5, 2, 2)); // ch2 next, ptr kept
        vt.push_back(mk(0, 0, 1, 4'hD, 1, 4'b0000, 0, 4'h5, 2, 2)); // selected ch idle

        @(posedge clk); #1;
        foreach (vt[i]) begin
            rst = vt[i].rst; mode = vt[i].mode; s = vt[i].s;
            in_valid = vt[i].vld; out_ready = vt[i].ordy;
            #1;
            chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vt[i].e_rdy));
            @(posedge clk); #1;
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vt[i].e_ov));
            chk($sformatf("v%0d out_data", i), 32'(out_data), 32'(vt[i].e_od));
            chk($sformatf("v%0d out_ch", i), 32'(out_ch), 32'(vt[i].e_ch));
            chk($sformatf("v%0d ptr", i), 32'(dut.r_ptr), 32'(vt[i].e_ptr));
        end

        // Streaming round-robin with per-cycle data; ptr is 2 here.
        rst = 1'b0; mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            logic [3:0] ech;
            logic [3:0] eod;
            for (int k = 0; k < 4; k++) in_data[k*4 +: 4] = 4'((c * 4 + k) & 15);
            ech = 4'((2 + c) % 4);
            eod = 4'((c * 4 + int'(ech)) & 15);
            @(posedge clk); #1;
            chk($sformatf("stream%0d out_valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("stream%0d out_ch", c), 32'(out_ch), 32'(ech));
            chk($sformatf("stream%0d out_data", c), 32'(out_data), 32'(eod));
        end

        // Reset while the output is stalled: word discarded, in_ready forced low.
        out_ready = 1'b0;
        @(posedge clk); #1;
        chk("stall held valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk("rst stall out_valid", 32'(out_valid), 32'd0);
        chk("rst stall out_data", 32'(out_data), 32'd0);
        rst = 1'b0; in_valid = 4'b1100; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post-rst grant ch", 32'(out_ch), 32'd2);
        chk("post-rst ptr", 32'(dut.r_ptr), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rr_mux_stage.md
# rr_mux_stage

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshaking on every input and on the output. It supports two modes: fixed select (the 4:1 combinational mux generalised) and round-robin arbitration across requesting channels. It sits between multiple producer streams and a single consumer, with one output register stage providing a full-throughput, back-pressure-aware selection point.

## Interface
- WIDTH, 4, data bits per channel (≥1)
- CHANNELS, 4, number of input channels (≥2); SEL_W = max(1, $clog2(CHANNELS))
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel word available
- in_ready  output  CHANNELS  per-channel accept (combinational)
- mode  input  1  0 = fixed select by s, 1 = round-robin
- s  input  SEL_W  channel select in fixed mode; ignored in round-robin mode
- out_data  output  WIDTH  registered selected word
- out_valid  output  1  out_data holds a word
- out_ready  input  1  consumer accepts
- out_ch  output  SEL_W  index of the channel that supplied out_data

## Operation
- Transfer on a port occurs in any cycle where valid & ready are both 1 at the rising clk edge.
- Output register is free when out_valid = 0 or out_ready = 1 (load-while-draining allowed).
- Grant (combinational, at most one bit set):
  - mode 0: grant[s] = in_valid[s]. Other channels are never granted. s ≥ CHANNELS gives no grant.
  - mode 1: first channel with in_valid set, searching from ptr upward and wrapping CHANNELS-1 → 0.
- in_ready[i] = grant[i] & output register free. in_ready never depends on in_ready or out_valid of the same cycle through any loop.
- On an accepted input from channel g: out_data ← in_data[g], out_ch ← g, out_valid ← 1.
- Free with no grant: out_valid ← 0. out_data and out_ch hold their values.
- Not free (out_valid = 1, out_ready = 0): out_data, out_ch, out_valid hold; all in_ready = 0.
- Round-robin pointer ptr (SEL_W bits):
  - On an accepted mode-1 transfer: ptr ← (g == CHANNELS-1) ? 0 : g+1.
  - Otherwise ptr holds. Mode-0 transfers do not move ptr.
- Mode or s changes take effect on the next cycle's grant. A word already in the output register is unaffected, and no word is lost or duplicated.

## Timing
- Reset (rst = 1 at edge): out_valid = 0, out_data = 0, out_ch = 0, ptr = 0. in_ready is forced to all 0 during any cycle in which rst = 1.
- Reset mid-operation discards any held output word. The first post-reset grant in mode 1 starts at channel 0.
- Latency: input accepted at edge k → visible on out_data/out_valid after edge k.
- Throughput: one word per cycle when out_ready = 1 continuously.
- Fairness (mode 1): with all channels valid, grant order is 0,1,…,CHANNELS-1,0,… A channel waits at most CHANNELS-1 transfers.
- Simultaneous output drain and input accept in the same cycle: the new word replaces the drained word, and out_valid stays 1.

## Test plan
- Fixed mode, reset → mode=0, WIDTH=4, in_data channels {0:0xA,1:0x3,2:0x5,3:0xC}, all valid, out_ready=1, step s=0..3 one per cycle. Required: out_data = 0xA,0x3,0x5,0xC one cycle after each select, out_ch = s, and ptr stays 0.
- Round-robin fairness → mode=1, all four valid, out_ready=1 for 8 cycles. Required: out_ch sequence 0,1,2,3,0,1,2,3 and out_valid continuously 1 after the first cycle.
- Sparse requests and wrap → mode=1, only channels 1 and 3 valid. Required: out_ch 1,3,1,3… Then drop channel 1 at ptr=2: channel 3 is granted, then ptr wraps to 0.
- Back-pressure → out_valid=1, out_ready=0 for 3 cycles while inputs are valid. Required: in_ready=0000, and out_data/out_ch are stable. When out_ready=1 the held word drains and the next word loads in the same cycle.
- Reset mid-stream → assert rst while out_valid=1 and ptr=2. Required: next cycle out_valid=0, out_data=0, out_ch=0, in_ready=0000. After release the first round-robin grant goes to channel 0.
- Mode switch → switch mode 1→0 with s=2 while a channel-1 word is held. Required: the channel-1 word is delivered intact, the next word comes from channel 2, and ptr is unchanged.
